// File: rtl/w_mat_bank.sv
// Layer-banked weight matrix store: a beat-wise load port assembles and writes one
// row at a time into a bank, while an independent read port streams rows of other banks.
module w_mat_bank #(
   parameter int    IN_C          = 34,
   parameter int    OUT_C         = 32,
   parameter int    W_WIDTH       = 8,
   parameter int    N_LAYER       = 2,
   parameter int    LD_WIDTH      = 32,
   parameter string MEM_INIT_FILE = "",
   localparam int   W_MEM_WIDTH   = OUT_C * W_WIDTH,
   localparam int   LAYER_W       = (N_LAYER > 1) ? $clog2(N_LAYER) : 1,
   localparam int   IDX_W         = (IN_C > 1) ? $clog2(IN_C) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ld_start,
   input  logic [LAYER_W-1:0]     ld_layer,
   input  logic                   ld_valid,
   output logic                   ld_ready,
   input  logic [LD_WIDTH-1:0]    ld_data,
   output logic                   ld_done,
   input  logic                   rd_valid,
   output logic                   rd_ready,
   input  logic [LAYER_W-1:0]     rd_layer,
   input  logic [IDX_W-1:0]       in_c_idx,
   output logic                   w_valid,
   input  logic                   w_ready,
   output logic [W_MEM_WIDTH-1:0] w_vec_pack,
   output logic                   rd_err
);

   localparam int BEATS  = W_MEM_WIDTH / LD_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DEPTH  = N_LAYER * IN_C;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] L_IDLE  = 2'd0;
   localparam logic [1:0] L_FILL  = 2'd1;
   localparam logic [1:0] L_WRITE = 2'd2;

   localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
   localparam logic [IDX_W-1:0]   LAST_ROW   = IDX_W'(IN_C - 1);
   localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(IN_C);
   localparam logic [LAYER_W:0]   LAYER_LIM  = (LAYER_W + 1)'(N_LAYER);
   localparam logic [IDX_W:0]     IDX_LIM    = (IDX_W + 1)'(IN_C);

   logic [1:0]             state;
   logic [LAYER_W-1:0]     ld_layer_q;
   logic [IDX_W-1:0]       row;
   logic [BEAT_W-1:0]      beat;
   logic [W_MEM_WIDTH-1:0] asm_row;
   logic [W_MEM_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]      wr_addr;
   logic [ADDR_W-1:0]      rd_addr;
   logic                   rd_in_range;
   logic                   bank_busy;
   logic                   rd_accept;

   // A bank under load is locked for reads, so the write and read ports never touch the same row.
   assign ld_ready    = (state == L_FILL);
   assign bank_busy   = (state != L_IDLE) && (rd_layer == ld_layer_q);
   assign rd_ready    = (!w_valid || w_ready) && !bank_busy;
   assign rd_accept   = rd_valid && rd_ready;
   assign rd_in_range = ({1'b0, rd_layer} < LAYER_LIM) && ({1'b0, in_c_idx} < IDX_LIM);
   assign wr_addr     = ADDR_W'(ld_layer_q) * ROW_STRIDE + ADDR_W'(row);
   assign rd_addr     = ADDR_W'(rd_layer) * ROW_STRIDE + ADDR_W'(in_c_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= L_IDLE;
         ld_layer_q <= '0;
         row        <= '0;
         beat       <= '0;
         ld_done    <= 1'b0;
         asm_row    <= '0;
      end else begin
         ld_done <= 1'b0;
         case (state)
            L_IDLE: begin
               if (ld_start) begin
                  ld_layer_q <= ld_layer;
                  row        <= '0;
                  beat       <= '0;
                  state      <= L_FILL;
               end
            end
            L_FILL: begin
               if (ld_valid) begin
                  for (int b = 0; b < BEATS; b++) begin
                     if (beat == BEAT_W'(b)) asm_row[b*LD_WIDTH +: LD_WIDTH] <= ld_data;
                  end
                  if (beat == LAST_BEAT) state <= L_WRITE;
                  else                   beat  <= beat + 1'b1;
               end
            end
            L_WRITE: begin
               beat <= '0;
               if (row == LAST_ROW) begin
                  ld_done <= 1'b1;
                  state   <= L_IDLE;
               end else begin
                  row   <= row + 1'b1;
                  state <= L_FILL;
               end
            end
            default: state <= L_IDLE;
         endcase
      end
   end

   // Storage is deliberately not reset so a reset mid-load keeps already written rows.
   always_ff @(posedge clk) begin
      if (state == L_WRITE) mem[wr_addr] <= asm_row;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_valid    <= 1'b0;
         w_vec_pack <= '0;
         rd_err     <= 1'b0;
      end else begin
         if (rd_accept) begin
            w_valid <= 1'b1;
            if (rd_in_range) begin
               w_vec_pack <= mem[rd_addr];
            end else begin
               w_vec_pack <= '0;
               rd_err     <= 1'b1;
            end
         end else if (w_ready) begin
            w_valid <= 1'b0;
         end
      end
   end

endmodule
